mem_arbiter_mc: RTL and testbench
=================================

# mem_arbiter_mc

Parametrised multi-channel memory controller between N_CH CPU-side request ports (e.g. instruction fetch, load/store) and a single narrow RAM port. It arbitrates round-robin among channels and splits each C_DATA_L-bit access into M_DATA_L-bit RAM beats at consecutive byte addresses, little-endian. It also supports per-byte write masking. It supersedes the single-channel, fixed-width controller between `riscv_cpu` and `ram`.

## Interface
- ADDR_L, 32, address width (byte addresses)
- M_DATA_L, 8, RAM data width per beat
- C_DATA_L, 32, client word width; must be a multiple of M_DATA_L; BEATS = C_DATA_L/M_DATA_L
- N_CH, 2, number of client channels (≥1); channel index width CW = max(1, clog2(N_CH))
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- c_re  in  N_CH  per-channel read request, held until c_rack
- c_we  in  N_CH  per-channel write request, held until c_wack
- c_raddr  in  N_CH*ADDR_L  read address, channel i at [i*ADDR_L +: ADDR_L]
- c_waddr  in  N_CH*ADDR_L  write address, same packing
- c_dout  in  N_CH*C_DATA_L  client write data
- c_wmask  in  N_CH*BEATS  byte-lane write enable per channel
- c_din  out  C_DATA_L  read data, shared by all channels
- c_rack  out  N_CH  one-cycle read-complete pulse
- c_wack  out  N_CH  one-cycle write-complete pulse
- m_re  out  1  RAM read strobe
- m_we  out  1  RAM write strobe
- m_raddr  out  ADDR_L  RAM read address
- m_waddr  out  ADDR_L  RAM write address
- m_dout  out  M_DATA_L  RAM write data
- m_din  in  M_DATA_L  RAM read data, valid when m_rack=1
- m_rack  in  1  RAM read beat done
- m_wack  in  1  RAM write beat done

## Operation
- FSM states: IDLE, RD, WR, DONE.
- IDLE: a channel requests if c_re[i] or c_we[i] is set. Grant goes to the first requester after last_grant, modulo N_CH. If none request, stay in IDLE.
- Latch for the granted channel: channel g, op, address, data, mask. Set beat counter k=0.
- If c_we[g] and c_re[g] are both set, the write is served first. The read stays pending for a later arbitration.
- RD: drive m_re=1, m_raddr = addr + k. On m_rack, store m_din into word[k*M_DATA_L +: M_DATA_L]. After the last beat, go to DONE. Otherwise k++ and keep m_re high with the new address.
- WR: skip beats whose mask bit is 0. For enabled beats, drive m_we=1, m_waddr = addr + k, m_dout = data lane k. On m_wack, advance to the next enabled beat. After the last one, go to DONE.
- An all-zero mask goes WR→DONE in one cycle with no RAM write.
- DONE: pulse c_rack[g] or c_wack[g] for exactly one cycle. For reads, c_din is updated to the assembled word that same cycle. Set last_grant=g and return to IDLE.
- c_din holds its value until the next read completes on any channel.
- Address arithmetic is modulo 2^ADDR_L: a word at 0xFFFF_FFFF wraps its beats to 0x0.
- Request inputs are sampled only in IDLE. A channel that drops its request mid-transaction still has the transaction completed and acked.
- m_re and m_we are never both high.

## Timing
- Reset (rst=1 at a clk edge) sets:
  - state=IDLE, last_grant=N_CH-1 (channel 0 wins first), k=0
  - all outputs to 0: c_din, c_rack, c_wack, m_re, m_we, m_raddr, m_waddr, m_dout
- Reset mid-transaction aborts immediately. No ack is issued, and m_re/m_we are low in the cycle after the reset edge.
- Read latency, from the cycle c_re is seen in IDLE to the c_rack cycle, is 1 + Σ(beat latencies) + 1. With RAM acking the cycle after strobe, BEATS=4 gives 1 + 8 + 1 = 10 cycles.
- Back-to-back: after DONE, the controller spends one IDLE cycle before the next grant.
- The ack cycle cannot re-grant the same request. The client must deassert its request in the cycle after the ack, or a new transaction starts.

## Test plan
- Read ch0, addr 0x100, RAM bytes 0x11,0x22,0x33,0x44 at 0x100..0x103 -> one c_rack[0] pulse, c_din=0x44332211, m_raddr sequence 0x100..0x103.
- Write ch1, addr 0x200, data 0xAABBCCDD, mask 4'b0101 -> RAM writes only 0x200=0xDD and 0x202=0xBB, exactly 2 m_we beats, one c_wack[1] pulse.
- ch0 and ch1 both request reads continuously from reset -> grants alternate 0,1,0,1, each ack one cycle, no channel served twice in a row.
- Mask 4'b0000 on ch0 write -> c_wack[0] two cycles after grant with m_we never asserted.
- Reset asserted during beat 2 of a read -> no c_rack; all outputs 0 the next cycle. A fresh read then returns correct data.
- N_CH=4, C_DATA_L=64, read at 0xFFFF_FFFC -> beats at 0xFFFF_FFFC..0xFFFF_FFFF then 0x0..0x3; 8 beats assembled little-endian.

Source files
------------

// File: rtl/mem_arbiter_mc.sv
// mem_arbiter_mc: round-robin arbiter between N_CH client ports and one narrow
// RAM port. Each client word is split into BEATS little-endian RAM beats at
// consecutive byte addresses; writes honour a per-beat byte-lane mask.
module mem_arbiter_mc #(
  parameter int ADDR_L   = 32,
  parameter int M_DATA_L = 8,
  parameter int C_DATA_L = 32,
  parameter int N_CH     = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_CH-1:0]                     c_re,
  input  logic [N_CH-1:0]                     c_we,
  input  logic [N_CH*ADDR_L-1:0]              c_raddr,
  input  logic [N_CH*ADDR_L-1:0]              c_waddr,
  input  logic [N_CH*C_DATA_L-1:0]            c_dout,
  input  logic [N_CH*(C_DATA_L/M_DATA_L)-1:0] c_wmask,
  output logic [C_DATA_L-1:0]                 c_din,
  output logic [N_CH-1:0]                     c_rack,
  output logic [N_CH-1:0]                     c_wack,
  output logic                                m_re,
  output logic                                m_we,
  output logic [ADDR_L-1:0]                   m_raddr,
  output logic [ADDR_L-1:0]                   m_waddr,
  output logic [M_DATA_L-1:0]                 m_dout,
  input  logic [M_DATA_L-1:0]                 m_din,
  input  logic                                m_rack,
  input  logic                                m_wack
);
  localparam int BEATS = C_DATA_L / M_DATA_L;
  localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t              r_state, w_state_next;
  logic [CW-1:0]       r_grant, r_last;
  logic                r_is_wr;
  logic [ADDR_L-1:0]   r_addr;
  logic [C_DATA_L-1:0] r_data, r_word, r_din;
  logic [BEATS-1:0]    r_mask;
  logic [KW-1:0]       r_k;

  // Per-channel views of the packed request buses
  logic [ADDR_L-1:0]   w_raddr_ch [N_CH];
  logic [ADDR_L-1:0]   w_waddr_ch [N_CH];
  logic [C_DATA_L-1:0] w_dout_ch  [N_CH];
  logic [BEATS-1:0]    w_mask_ch  [N_CH];

  // Arbitration
  logic [N_CH-1:0]     w_req, w_after_last, w_req_hi, w_pick_from, w_pick_oh;
  logic [N_CH-1:0]     w_gnt_col [CW];
  logic [CW-1:0]       w_gnt;
  logic                w_any_req, w_gnt_wr;

  // Beat selection and read assembly
  logic [BEATS-1:0]    w_from_k, w_rem, w_cur_oh;
  logic [BEATS-1:0]    w_cur_col [KW];
  logic [KW-1:0]       w_cur, w_beat;
  logic                w_more, w_last_rd;
  logic [M_DATA_L-1:0] w_data_lane [BEATS];
  logic [C_DATA_L-1:0] w_word_asm;

  genvar gi, gb;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign w_raddr_ch[gi]   = c_raddr[gi*ADDR_L +: ADDR_L];
      assign w_waddr_ch[gi]   = c_waddr[gi*ADDR_L +: ADDR_L];
      assign w_dout_ch[gi]    = c_dout[gi*C_DATA_L +: C_DATA_L];
      assign w_mask_ch[gi]    = c_wmask[gi*BEATS +: BEATS];
      assign w_after_last[gi] = (CW'(gi) > r_last);
      assign c_rack[gi]       = (r_state == DONE) && !r_is_wr && (r_grant == CW'(gi));
      assign c_wack[gi]       = (r_state == DONE) &&  r_is_wr && (r_grant == CW'(gi));
      for (gb = 0; gb < CW; gb++) begin : g_col
        assign w_gnt_col[gb][gi] = ((gi >> gb) & 1) != 0;
      end
    end
    // One-hot to binary: bit gb of the grant is set if the chosen channel has it
    for (gb = 0; gb < CW; gb++) begin : g_gnt_bit
      assign w_gnt[gb] = |(w_pick_oh & w_gnt_col[gb]);
    end

    for (gi = 0; gi < BEATS; gi++) begin : g_lane
      assign w_data_lane[gi] = r_data[gi*M_DATA_L +: M_DATA_L];
      assign w_from_k[gi]    = (KW'(gi) >= r_k);
      assign w_word_asm[gi*M_DATA_L +: M_DATA_L] =
        (r_k == KW'(gi)) ? m_din : r_word[gi*M_DATA_L +: M_DATA_L];
      for (gb = 0; gb < KW; gb++) begin : g_col
        assign w_cur_col[gb][gi] = ((gi >> gb) & 1) != 0;
      end
    end
    for (gb = 0; gb < KW; gb++) begin : g_cur_bit
      assign w_cur[gb] = |(w_cur_oh & w_cur_col[gb]);
    end
  endgenerate

  // Round robin: prefer requesters above last_grant, else wrap to the lowest
  assign w_req       = c_re | c_we;
  assign w_any_req   = |w_req;
  assign w_req_hi    = w_req & w_after_last;
  assign w_pick_from = (|w_req_hi) ? w_req_hi : w_req;
  assign w_pick_oh   = w_pick_from & (~w_pick_from + N_CH'(1));
  assign w_gnt_wr    = c_we[w_gnt];

  // Writes jump straight to the next enabled lane at or after k
  assign w_rem     = r_mask & w_from_k;
  assign w_cur_oh  = w_rem & (~w_rem + BEATS'(1));
  assign w_more    = |(w_rem & ~w_cur_oh);
  assign w_beat    = (r_state == WR) ? w_cur : r_k;
  assign w_last_rd = (r_k == KW'(BEATS-1));

  assign c_din   = r_din;
  assign m_raddr = r_addr + ADDR_L'(w_beat);
  assign m_waddr = r_addr + ADDR_L'(w_beat);
  assign m_dout  = w_data_lane[w_beat];

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and RAM strobes
  always_comb begin
    w_state_next = r_state;
    m_re         = 1'b0;
    m_we         = 1'b0;
    unique case (r_state)
      IDLE: if (w_any_req) w_state_next = w_gnt_wr ? WR : RD;
      RD: begin
        m_re = 1'b1;
        if (m_rack && w_last_rd) w_state_next = DONE;
      end
      WR: begin
        if (!(|w_rem)) begin
          w_state_next = DONE;
        end else begin
          m_we = 1'b1;
          if (m_wack && !w_more) w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Transaction latch, beat counter and read-word assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant <= '0;
      r_last  <= CW'(N_CH-1);
      r_is_wr <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_word  <= '0;
      r_din   <= '0;
      r_mask  <= '0;
      r_k     <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_any_req) begin
          r_grant <= w_gnt;
          r_is_wr <= w_gnt_wr;
          r_addr  <= w_gnt_wr ? w_waddr_ch[w_gnt] : w_raddr_ch[w_gnt];
          r_data  <= w_dout_ch[w_gnt];
          r_mask  <= w_gnt_wr ? w_mask_ch[w_gnt] : '0;
          r_k     <= '0;
        end
        RD: if (m_rack) begin
          r_word <= w_word_asm;
          if (w_last_rd) r_din <= w_word_asm;
          else           r_k   <= r_k + KW'(1);
        end
        WR: if ((|w_rem) && m_wack && w_more) r_k <= w_cur + KW'(1);
        DONE: r_last <= r_grant;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter_mc.sv
// Directed testbench for mem_arbiter_mc: a 2-channel 32-bit instance and a
// 4-channel 64-bit instance, each with a byte RAM that acks one cycle after strobe.
`timescale 1ns/1ps
module tb_mem_arbiter_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 2-channel, 32-bit client instance
  logic [1:0]  c_re, c_we, c_rack, c_wack;
  logic [63:0] c_raddr, c_waddr, c_dout;
  logic [7:0]  c_wmask;
  logic [31:0] c_din, m_raddr, m_waddr;
  logic        m_re, m_we, m_rack, m_wack;
  logic [7:0]  m_dout, m_din;

  // 4-channel, 64-bit client instance
  logic [3:0]   c_re4, c_we4, c_rack4, c_wack4;
  logic [127:0] c_raddr4, c_waddr4;
  logic [255:0] c_dout4;
  logic [31:0]  c_wmask4, m_raddr4, m_waddr4;
  logic [63:0]  c_din4;
  logic         m_re4, m_we4, m_rack4, m_wack4;
  logic [7:0]   m_dout4, m_din4;

  mem_arbiter_mc #(.ADDR_L(32), .M_DATA_L(8), .C_DATA_L(32), .N_CH(2)) dut (
    .clk(clk), .rst(rst), .c_re(c_re), .c_we(c_we), .c_raddr(c_raddr), .c_waddr(c_waddr),
    .c_dout(c_dout), .c_wmask(c_wmask), .c_din(c_din), .c_rack(c_rack), .c_wack(c_wack),
    .m_re(m_re), .m_we(m_we), .m_raddr(m_raddr), .m_waddr(m_waddr), .m_dout(m_dout),
    .m_din(m_din), .m_rack(m_rack), .m_wack(m_wack));

  mem_arbiter_mc #(.ADDR_L(32), .M_DATA_L(8), .C_DATA_L(64), .N_CH(4)) dut4 (
    .clk(clk), .rst(rst), .c_re(c_re4), .c_we(c_we4), .c_raddr(c_raddr4), .c_waddr(c_waddr4),
    .c_dout(c_dout4), .c_wmask(c_wmask4), .c_din(c_din4), .c_rack(c_rack4), .c_wack(c_wack4),
    .m_re(m_re4), .m_we(m_we4), .m_raddr(m_raddr4), .m_waddr(m_waddr4), .m_dout(m_dout4),
    .m_din(m_din4), .m_rack(m_rack4), .m_wack(m_wack4));

  logic [7:0]  mem  [0:4095];
  logic [7:0]  mem4 [0:4095];
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [7:0]  pl_data;
  logic [31:0] rd_log [0:255];
  logic [31:0] wr_log [0:255];
  logic [31:0] rd4_log [0:63];
  int rd_n = 0, wr_n = 0, rd4_n = 0;

  // RAM models: one beat acked the cycle after a fresh strobe; also backdoor preload
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr]  <= pl_data;
      mem4[pl_addr] <= pl_data;
    end
    if (rst) begin
      m_rack <= 1'b0; m_wack <= 1'b0; m_din <= 8'h00;
      m_rack4 <= 1'b0; m_wack4 <= 1'b0; m_din4 <= 8'h00;
    end else begin
      m_rack <= m_re && !m_rack;
      if (m_re && !m_rack) begin
        m_din <= mem[m_raddr[11:0]];
        if (rd_n < 256) rd_log[rd_n] <= m_raddr;
        rd_n <= rd_n + 1;
      end
      m_wack <= m_we && !m_wack;
      if (m_we && !m_wack) begin
        mem[m_waddr[11:0]] <= m_dout;
        if (wr_n < 256) wr_log[wr_n] <= m_waddr;
        wr_n <= wr_n + 1;
      end
      m_rack4 <= m_re4 && !m_rack4;
      if (m_re4 && !m_rack4) begin
        m_din4 <= mem4[m_raddr4[11:0]];
        if (rd4_n < 64) rd4_log[rd4_n] <= m_raddr4;
        rd4_n <= rd4_n + 1;
      end
      m_wack4 <= m_we4 && !m_wack4;
    end
  end

  int rack0_n = 0, rack1_n = 0, wack0_n = 0, wack1_n = 0, we_cyc = 0, both_hi = 0;

  // Pulse and strobe counters, sampled mid-cycle
  always @(negedge clk) begin
    if (c_rack[0]) rack0_n++;
    if (c_rack[1]) rack1_n++;
    if (c_wack[0]) wack0_n++;
    if (c_wack[1]) wack1_n++;
    if (m_we) we_cyc++;
    if ((m_re && m_we) || (m_re4 && m_we4)) both_hi++;
  end

  int n_pass = 0, n_total = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_total++; if (c_din !== 32'h0) $display("FAIL reset_c_din: got %h expected 0", c_din); else n_pass++;
    n_total++; if (c_rack !== 2'b00) $display("FAIL reset_c_rack: got %b expected 00", c_rack); else n_pass++;
    n_total++; if (c_wack !== 2'b00) $display("FAIL reset_c_wack: got %b expected 00", c_wack); else n_pass++;
    n_total++; if (m_re !== 1'b0 || m_we !== 1'b0) $display("FAIL reset_strobes: got re=%b we=%b expected 0 0", m_re, m_we); else n_pass++;
    n_total++; if (m_raddr !== 32'h0 || m_waddr !== 32'h0) $display("FAIL reset_addr: got %h %h expected 0 0", m_raddr, m_waddr); else n_pass++;
    n_total++; if (m_dout !== 8'h0) $display("FAIL reset_m_dout: got %h expected 0", m_dout); else n_pass++;
    rst = 1'b0;
    tick();
    n_total++; if (m_re !== 1'b0) $display("FAIL idle_no_req: got m_re=%b expected 0", m_re); else n_pass++;
    $display("reset done");
  endtask

  task automatic test_read();
    int n, base, r0;
    base = rd_n; r0 = rack0_n;
    c_raddr[31:0] = 32'h100; c_re[0] = 1'b1;
    n = 0;
    while (c_rack[0] !== 1'b1 && n < 40) begin tick(); n++; end
    $display("read ch0 addr 00000100 data %h latency %0d", c_din, n + 1);
    n_total++; if (n !== 9) $display("FAIL read_latency: got %0d expected 9", n); else n_pass++;
    n_total++; if (c_din !== 32'h44332211) $display("FAIL read_data: got %h expected 44332211", c_din); else n_pass++;
    c_re[0] = 1'b0;
    tick();
    n_total++; if (c_rack !== 2'b00) $display("FAIL read_ack_width: got %b expected 00", c_rack); else n_pass++;
    repeat (3) tick();
    n_total++; if (rack0_n - r0 !== 1) $display("FAIL read_ack_count: got %0d expected 1", rack0_n - r0); else n_pass++;
    n_total++; if (rd_n - base !== 4) $display("FAIL read_beats: got %0d expected 4", rd_n - base); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (rd_log[base+i] !== 32'h100 + 32'(i)) $display("FAIL read_addr_seq: beat %0d got %h expected %h", i, rd_log[base+i], 32'h100 + 32'(i));
      else n_pass++;
    end
    n_total++; if (c_din !== 32'h44332211) $display("FAIL read_data_hold: got %h expected 44332211", c_din); else n_pass++;
  endtask

  task automatic test_write_mask();
    int n, base, w1, w0;
    base = wr_n; w1 = wack1_n; w0 = wack0_n;
    c_waddr[63:32] = 32'h200; c_dout[63:32] = 32'hAABBCCDD; c_wmask[7:4] = 4'b0101; c_we[1] = 1'b1;
    n = 0;
    while (c_wack[1] !== 1'b1 && n < 40) begin tick(); n++; end
    $display("write ch1 addr 00000200 data aabbccdd mask 0101 latency %0d", n + 1);
    n_total++; if (n !== 5) $display("FAIL write_latency: got %0d expected 5", n); else n_pass++;
    c_we[1] = 1'b0;
    repeat (3) tick();
    n_total++; if (wr_n - base !== 2) $display("FAIL write_beats: got %0d expected 2", wr_n - base); else n_pass++;
    n_total++; if (wr_log[base] !== 32'h200 || wr_log[base+1] !== 32'h202) $display("FAIL write_addrs: got %h %h expected 00000200 00000202", wr_log[base], wr_log[base+1]); else n_pass++;
    n_total++; if ({mem[12'h203], mem[12'h202], mem[12'h201], mem[12'h200]} !== 32'hEEBBEEDD)
      $display("FAIL write_mem: got %h expected eebbeedd", {mem[12'h203], mem[12'h202], mem[12'h201], mem[12'h200]}); else n_pass++;
    n_total++; if (wack1_n - w1 !== 1 || wack0_n !== w0) $display("FAIL write_ack: got ch1=%0d ch0=%0d expected 1 0", wack1_n - w1, wack0_n - w0); else n_pass++;
  endtask

  task automatic test_zero_mask();
    int n, we0, w0;
    we0 = we_cyc; w0 = wack0_n;
    c_waddr[31:0] = 32'h300; c_dout[31:0] = 32'h12345678; c_wmask[3:0] = 4'b0000; c_we[0] = 1'b1;
    n = 0;
    while (c_wack[0] !== 1'b1 && n < 40) begin tick(); n++; end
    $display("write ch0 addr 00000300 mask 0000 ack after %0d cycles", n);
    n_total++; if (n !== 2) $display("FAIL zero_mask_latency: got %0d expected 2", n); else n_pass++;
    c_we[0] = 1'b0;
    repeat (3) tick();
    n_total++; if (we_cyc !== we0) $display("FAIL zero_mask_no_we: got %0d we cycles expected 0", we_cyc - we0); else n_pass++;
    n_total++; if (mem[12'h300] !== 8'h5A) $display("FAIL zero_mask_mem: got %h expected 5a", mem[12'h300]); else n_pass++;
    n_total++; if (wack0_n - w0 !== 1) $display("FAIL zero_mask_ack_count: got %0d expected 1", wack0_n - w0); else n_pass++;
  endtask

  task automatic test_round_robin();
    int n, a0, a1;
    logic [1:0]  exp_v;
    logic [31:0] exp_d;
    rst = 1'b1;
    c_raddr = {32'h200, 32'h100}; c_re = 2'b11;
    repeat (2) tick();
    rst = 1'b0;
    a0 = rack0_n; a1 = rack1_n;
    for (int a = 0; a < 4; a++) begin
      exp_v = (a % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (a % 2 == 0) ? 32'h44332211 : 32'hEEBBEEDD;
      n = 0;
      while (c_rack === 2'b00 && n < 40) begin tick(); n++; end
      $display("rr read ack %b data %h", c_rack, c_din);
      n_total++; if (c_rack !== exp_v) $display("FAIL rr_grant_%0d: got %b expected %b", a, c_rack, exp_v); else n_pass++;
      n_total++; if (c_din !== exp_d) $display("FAIL rr_data_%0d: got %h expected %h", a, c_din, exp_d); else n_pass++;
      if (a == 3) c_re = 2'b00;
      tick();
      n_total++; if (c_rack !== 2'b00) $display("FAIL rr_ack_width_%0d: got %b expected 00", a, c_rack); else n_pass++;
    end
    repeat (12) tick();
    n_total++; if ((rack0_n - a0) !== 2 || (rack1_n - a1) !== 2) $display("FAIL rr_ack_totals: got %0d %0d expected 2 2", rack0_n - a0, rack1_n - a1); else n_pass++;
    n_total++; if (both_hi !== 0) $display("FAIL strobe_exclusive: got %0d overlapping cycles expected 0", both_hi); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n, r0;
    r0 = rack0_n;
    c_raddr[31:0] = 32'h100; c_re = 2'b01;
    n = 0;
    while (!(m_re === 1'b1 && m_raddr === 32'h102) && n < 40) begin tick(); n++; end
    n_total++; if (m_raddr !== 32'h102) $display("FAIL mid_beat2_reached: got %h expected 00000102", m_raddr); else n_pass++;
    rst = 1'b1; c_re = 2'b00;
    tick();
    $display("reset during read beat 2");
    n_total++; if (c_rack !== 2'b00 || c_wack !== 2'b00) $display("FAIL mid_acks: got %b %b expected 00 00", c_rack, c_wack); else n_pass++;
    n_total++; if (m_re !== 1'b0 || m_we !== 1'b0) $display("FAIL mid_strobes: got re=%b we=%b expected 0 0", m_re, m_we); else n_pass++;
    n_total++; if (m_raddr !== 32'h0 || m_waddr !== 32'h0 || m_dout !== 8'h0) $display("FAIL mid_ram_bus: got %h %h %h expected 0 0 0", m_raddr, m_waddr, m_dout); else n_pass++;
    n_total++; if (c_din !== 32'h0) $display("FAIL mid_c_din: got %h expected 0", c_din); else n_pass++;
    rst = 1'b0;
    repeat (3) tick();
    n_total++; if (rack0_n !== r0) $display("FAIL mid_no_ack: got %0d acks expected 0", rack0_n - r0); else n_pass++;
    c_re = 2'b01;
    n = 0;
    while (c_rack[0] !== 1'b1 && n < 40) begin tick(); n++; end
    $display("read ch0 addr 00000100 data %h after reset", c_din);
    n_total++; if (c_din !== 32'h44332211 || n !== 9) $display("FAIL mid_fresh_read: got %h after %0d expected 44332211 after 9", c_din, n); else n_pass++;
    c_re = 2'b00;
    repeat (2) tick();
  endtask

  task automatic test_wide_wrap();
    int n, base;
    logic [31:0] ea;
    base = rd4_n;
    c_raddr4[2*32 +: 32] = 32'hFFFF_FFFC; c_re4 = 4'b0100;
    n = 0;
    while (c_rack4 === 4'b0000 && n < 60) begin tick(); n++; end
    $display("wide read ch2 addr fffffffc data %h ack %b", c_din4, c_rack4);
    n_total++; if (n !== 17) $display("FAIL wide_latency: got %0d expected 17", n); else n_pass++;
    n_total++; if (c_rack4 !== 4'b0100) $display("FAIL wide_ack: got %b expected 0100", c_rack4); else n_pass++;
    n_total++; if (c_din4 !== 64'h0807060504030201) $display("FAIL wide_data: got %h expected 0807060504030201", c_din4); else n_pass++;
    c_re4 = 4'b0000;
    tick();
    n_total++; if (rd4_n - base !== 8) $display("FAIL wide_beats: got %0d expected 8", rd4_n - base); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      ea = 32'hFFFF_FFFC + 32'(i);
      n_total++;
      if (rd4_log[base+i] !== ea) $display("FAIL wide_addr_seq: beat %0d got %h expected %h", i, rd4_log[base+i], ea);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    c_re = '0; c_we = '0; c_raddr = '0; c_waddr = '0; c_dout = '0; c_wmask = '0;
    c_re4 = '0; c_we4 = '0; c_raddr4 = '0; c_waddr4 = '0; c_dout4 = '0; c_wmask4 = '0;
    test_reset();
    preload(12'h100, 8'h11); preload(12'h101, 8'h22); preload(12'h102, 8'h33); preload(12'h103, 8'h44);
    for (int i = 0; i < 4; i++) preload(12'h200 + 12'(i), 8'hEE);
    preload(12'h300, 8'h5A);
    for (int i = 0; i < 4; i++) preload(12'hFFC + 12'(i), 8'h01 + 8'(i));
    for (int i = 0; i < 4; i++) preload(12'h000 + 12'(i), 8'h05 + 8'(i));
    test_read();
    test_write_mask();
    test_zero_mask();
    test_round_robin();
    test_reset_mid();
    test_wide_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
